// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcodes, ALU and operand-select encodings, decode bundle type
package riscv_pkg;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [1:0] OP1_SEL_RS1  = 2'b00;
   localparam logic [1:0] OP1_SEL_PC   = 2'b01;
   localparam logic [1:0] OP1_SEL_ZERO = 2'b10;
   typedef struct packed {
      logic [3:0]  alu_op;
      logic [1:0]  op1_sel;
      logic        op2_sel;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic [31:0] pc;
   } ctrl_t;
   localparam ctrl_t CTRL_NOP = ctrl_t'{ALU_ADD, OP1_SEL_RS1, 1'b1, 32'd0, 5'd0, 5'd0, 5'd0,
                                        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
endpackage

// File: rtl/id_decode_stage_imm_gen.sv
// imm_gen: sign-extended RV32I immediate selected by opcode format
module imm_gen
   import riscv_pkg::*;
(
   input  logic [31:0] instr,
   output logic [31:0] imm
);
   logic [6:0]  opc;
   logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
   always_comb begin
      opc   = instr[6:0];
      i_imm = {{20{instr[31]}}, instr[31:20]};
      s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      u_imm = {instr[31:12], 12'd0};
      j_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      // shift-immediates carry only the shamt; funct7 is not part of the operand
      imm = (opc == OPC_LOAD || opc == OPC_JALR) ? i_imm :
            (opc == OPC_OP_IMM) ? ((instr[13:12] == 2'b01) ? {27'd0, instr[24:20]} : i_imm) :
            (opc == OPC_STORE) ? s_imm :
            (opc == OPC_BRANCH) ? b_imm :
            (opc == OPC_LUI || opc == OPC_AUIPC) ? u_imm :
            (opc == OPC_JAL) ? j_imm : 32'd0;
   end
endmodule

// File: rtl/id_decode_stage.sv
// id_decode_stage: RV32I decode with one registered valid/ready stage and flush.
// Define ID_ILLEGAL_TRAP_EN to add the illegal output flagging unsupported encodings.
module id_decode_stage
   import riscv_pkg::*;
#(
   parameter int          XLEN      = 32,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      alu_op,
   output logic [1:0]      op1_sel,
   output logic            op2_sel,
   output logic [XLEN-1:0] imm,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic            reg_write,
   output logic            mem_read,
   output logic            mem_write,
   output logic            branch,
   output logic            jump,
   output logic [XLEN-1:0] out_pc
`ifdef ID_ILLEGAL_TRAP_EN
   ,
   output logic            illegal
`endif
);
   ctrl_t       dec, bundle_d, bundle_q;
   logic        out_valid_d, out_valid_q, transfer, load_nop, ok, writes;
   logic [31:0] instr, imm_w;
   logic [6:0]  opc, f7;
   logic [2:0]  f3;
   assign load_nop = rst || flush;
   assign instr    = load_nop ? NOP_INSTR : in_instr;
   assign in_ready = !out_valid_q || out_ready;
   assign transfer = in_valid && in_ready;
   imm_gen u_imm_gen (.instr(instr), .imm(imm_w));
   always_comb begin
      opc    = instr[6:0];
      f3     = instr[14:12];
      f7     = instr[31:25];
      dec    = CTRL_NOP;
      ok     = 1'b1;
      writes = 1'b0;
      case (opc)
         OPC_OP: begin
            ok          = f7 == 7'h00 || f7 == 7'h20;
            dec.alu_op  = {f7[5], f3};
            dec.op2_sel = 1'b0;
            dec.rs1     = instr[19:15];
            dec.rs2     = instr[24:20];
            writes      = 1'b1;
         end
         OPC_OP_IMM: begin
            ok         = (f3 == 3'b001) ? f7 == 7'h00 :
                         (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            dec.alu_op = {f3 == 3'b101 && f7[5], f3};
            dec.rs1    = instr[19:15];
            writes     = 1'b1;
         end
         OPC_LOAD: begin
            dec.mem_read = 1'b1;
            dec.rs1      = instr[19:15];
            writes       = 1'b1;
         end
         OPC_STORE: begin
            dec.mem_write = 1'b1;
            dec.rs1       = instr[19:15];
            dec.rs2       = instr[24:20];
         end
         OPC_BRANCH: begin
            dec.alu_op  = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
            dec.op2_sel = 1'b0;
            dec.branch  = 1'b1;
            dec.rs1     = instr[19:15];
            dec.rs2     = instr[24:20];
         end
         OPC_JAL: begin
            dec.op1_sel = OP1_SEL_PC;
            dec.jump    = 1'b1;
            writes      = 1'b1;
         end
         OPC_JALR: begin
            dec.jump = 1'b1;
            dec.rs1  = instr[19:15];
            writes   = 1'b1;
         end
         OPC_LUI: begin
            dec.op1_sel = OP1_SEL_ZERO;
            writes      = 1'b1;
         end
         OPC_AUIPC: begin
            dec.op1_sel = OP1_SEL_PC;
            writes      = 1'b1;
         end
         default: ok = 1'b0;
      endcase
      dec.imm       = imm_w;
      dec.rd        = writes ? instr[11:7] : 5'd0;
      dec.reg_write = writes && instr[11:7] != 5'd0;
      if (!ok) dec = CTRL_NOP;
      dec.pc        = load_nop ? 32'd0 : in_pc;
      bundle_d      = (load_nop || transfer) ? dec : bundle_q;
      out_valid_d   = flush ? 1'b0 : transfer ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
   end
`ifdef ID_ILLEGAL_TRAP_EN
   logic illegal_d, illegal_q;
   assign illegal_d = (load_nop || transfer) ? !ok : illegal_q;
   assign illegal   = illegal_q;
   always_ff @(posedge clk) illegal_q <= illegal_d;
`endif
   always_ff @(posedge clk) begin
      if (rst) out_valid_q <= 1'b0;
      else out_valid_q <= out_valid_d;
      bundle_q <= bundle_d;
   end
   assign out_valid = out_valid_q;
   assign alu_op    = bundle_q.alu_op;
   assign op1_sel   = bundle_q.op1_sel;
   assign op2_sel   = bundle_q.op2_sel;
   assign imm       = bundle_q.imm;
   assign rs1       = bundle_q.rs1;
   assign rs2       = bundle_q.rs2;
   assign rd        = bundle_q.rd;
   assign reg_write = bundle_q.reg_write;
   assign mem_read  = bundle_q.mem_read;
   assign mem_write = bundle_q.mem_write;
   assign branch    = bundle_q.branch;
   assign jump      = bundle_q.jump;
   assign out_pc    = bundle_q.pc;
endmodule
